vt512_patch_tokenizer: RTL and testbench
========================================

VT512_PATCH_TOKENIZER -- requirements
Module: vt512_patch_tokenizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel/token word width.
REQ-002 SHALL have parameter MAX_IMAGE_SIZE, default 512, max square image side in pixels.
REQ-003 SHALL have parameter PATCH_SIZE, default 16, square patch side; power of two, at most MAX_IMAGE_SIZE.
REQ-004 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 image_size  in  $clog2(MAX_IMAGE_SIZE)+1  image side W from image capture.
REQ-007 size_detection_done  in  1  one-cycle pulse; image_size valid this cycle.
REQ-008 pix_valid / pix_ready  in / out  1 / 1  raster-order pixel handshake.
REQ-009 pix_data  in  DATA_WIDTH  one pixel per word.
REQ-010 tok_valid / tok_ready  out / in  1 / 1  patch-order token handshake.
REQ-011 tok_data  out  DATA_WIDTH  token word.
REQ-012 tok_last  out  1  high on the last word of each patch.
REQ-013 patch_idx  out  16  raster index of the patch being emitted.
REQ-014 frame_done  out  1  one-cycle pulse after the last word of the frame is accepted.
REQ-015 size_err  out  1  sticky; set on an illegal image_size.

Function
REQ-016 The block SHALL use an internal strip buffer of PATCH_SIZE x MAX_IMAGE_SIZE words with one-cycle read latency.
REQ-017 States SHALL be IDLE, FILL, DRAIN, DISCARD.
REQ-018 IDLE: pix_ready=0; on size_detection_done with PATCH_SIZE<=image_size<=MAX_IMAGE_SIZE, latch W, clear strip/row/col counters, go FILL; otherwise set size_err and stay in IDLE.
REQ-019 FILL: pix_ready=1; each pix_valid&&pix_ready writes buffer[row][col]; col wraps at W-1 and increments row; completing row PATCH_SIZE-1 goes to DRAIN on the next cycle.
REQ-020 DRAIN: pix_ready=0; for each patch p = 0..NPX-1, emit rows r = 0..PATCH_SIZE-1 and, within each row, columns c = 0..PATCH_SIZE-1, reading buffer[r][p*PATCH_SIZE+c]; patch_idx = strip*NPX+p.
REQ-021 tok_data, tok_last, and patch_idx SHALL be registered and SHALL stay stable while tok_valid && !tok_ready; the counters advance only on a tok_valid&&tok_ready handshake.
REQ-022 After the last word of the last patch of a strip: if more strips remain, go FILL; otherwise pulse frame_done and go to IDLE, or to DISCARD if unconsumed input rows remain (REQ-031).
REQ-023 DISCARD: pix_ready=1; accept and drop pixels until all W*W pixels of the frame are consumed, then go IDLE.
REQ-024 A size_detection_done pulse outside IDLE SHALL be ignored.
REQ-025 tok_valid SHALL never be asserted outside DRAIN; pix_ready and tok_valid SHALL never be high in the same cycle.
REQ-026 Counters SHALL be wide enough for MAX_IMAGE_SIZE; no wrap-around other than col and row.

Reset
REQ-027 wb_rst_i SHALL force state IDLE and clear all counters; pix_ready, tok_valid, tok_last, frame_done, size_err, and patch_idx SHALL be 0, and tok_data 0.
REQ-028 Reset mid-frame SHALL abandon the frame without emitting frame_done; the buffer contents need not be cleared.

Configuration
REQ-029 Macro VT512_PATCH_ZEROPAD_EN SHALL select the edge handling.
REQ-030 When the macro is defined: NPX = NSTRIPS = ceil(W/PATCH_SIZE); token positions with column >= W or image row >= W SHALL output 0; the final partial strip enters DRAIN once its last real row is written.
REQ-031 When the macro is undefined: NPX = NSTRIPS = floor(W/PATCH_SIZE); pixels with column >= NPX*PATCH_SIZE SHALL be accepted but not written; rows beyond NSTRIPS*PATCH_SIZE are consumed in DISCARD.

Verification
REQ-032 All scenarios SHALL use PATCH_SIZE=4, MAX_IMAGE_SIZE=16, and pix_data = row*16+col.
REQ-033 W=8, tok_ready=1: 4 patches of 16 words; patch 1 begins 0x04,0x05,0x06,0x07,0x14; tok_last on every 16th word; frame_done once.
REQ-034 W=8, random tok_ready stalls -> token sequence identical to REQ-033; tok_data stable during stalls.
REQ-035 W=6, macro defined -> 4 patches; patch 1 row 0 = 0x04,0x05,0,0; patch 3 rows 2-3 all 0.
REQ-036 W=6, macro undefined -> 1 patch (0x00..0x33); all 36 pixels accepted; frame_done once; then IDLE.
REQ-037 image_size=3 or 17 -> size_err=1, pix_ready stays 0; reset clears size_err; reset asserted mid-DRAIN -> IDLE next cycle, tok_valid=0, no frame_done.

Source files
------------

// File: rtl/vt512_patch_tokenizer.sv
// vt512_patch_tokenizer: converts a raster-order square image into patch-order
// tokens using a strip buffer that holds PATCH_SIZE image rows.
// Build option: define VT512_PATCH_ZEROPAD_EN to pad partial edge patches with
// zeros. Without it, partial edge columns and rows are consumed and dropped.
module vt512_patch_tokenizer #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_IMAGE_SIZE = 512,
  parameter int PATCH_SIZE     = 16
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [$clog2(MAX_IMAGE_SIZE):0]   image_size,
  input  logic                              size_detection_done,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic [DATA_WIDTH-1:0]             pix_data,
  output logic                              tok_valid,
  input  logic                              tok_ready,
  output logic [DATA_WIDTH-1:0]             tok_data,
  output logic                              tok_last,
  output logic [15:0]                       patch_idx,
  output logic                              frame_done,
  output logic                              size_err
);

  localparam int SW      = $clog2(MAX_IMAGE_SIZE) + 1;
  localparam int LOG2_PS = $clog2(PATCH_SIZE);
  localparam int DEPTH   = PATCH_SIZE * MAX_IMAGE_SIZE;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [SW-1:0] PS_W  = SW'(PATCH_SIZE);
  localparam logic [SW-1:0] PS_M1 = SW'(PATCH_SIZE - 1);
  localparam logic [SW-1:0] MAX_W = SW'(MAX_IMAGE_SIZE);
  localparam logic [SW-1:0] ONE   = SW'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DISCARD} state_t;
  state_t state_reg, state_next;

  // Frame geometry and fill-side position
  logic [SW-1:0] w_reg, npx_reg, strip_reg, row_reg, col_reg, img_row_reg;
  // Drain-side position of the next word to fetch
  logic [SW-1:0] p_reg, r_reg, c_reg;
  logic [15:0]   strip_base_reg, patch_idx_reg;
  logic          tok_valid_reg, tok_last_reg, strip_end_reg;
  logic          frame_done_reg, size_err_reg;
  logic [DATA_WIDTH-1:0] tok_data_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          size_ok, pix_hs, tok_hs, col_last;
  logic          fill_end, discard_end, drain_load, drain_exit, more_strips;
  logic          wr_en, rd_zero;
  logic [SW-1:0] npx_new;
  logic [31:0]   dcol;
  logic [AW-1:0] wr_addr, rd_addr;

  assign pix_ready = (state_reg == FILL) || (state_reg == DISCARD);
  assign size_ok   = (image_size >= PS_W) && (image_size <= MAX_W);
  assign pix_hs    = pix_valid && pix_ready;
  assign tok_hs    = tok_valid_reg && tok_ready;
  assign col_last  = (col_reg == w_reg - ONE);

  // A strip ends on its last row, or early on the last image row (partial strip).
  assign fill_end    = (state_reg == FILL) && pix_hs && col_last &&
                       ((row_reg == PS_M1) || (img_row_reg == w_reg - ONE));
  assign discard_end = (state_reg == DISCARD) && pix_hs && col_last &&
                       (img_row_reg == w_reg - ONE);
  // Fetch a word on DRAIN entry (output empty) or when the shown word is taken.
  assign drain_load  = (state_reg == DRAIN) &&
                       (!tok_valid_reg || (tok_hs && !strip_end_reg));
  assign drain_exit  = (state_reg == DRAIN) && tok_hs && strip_end_reg;
  assign more_strips = (strip_reg + ONE) < npx_reg;

  assign dcol    = (32'(p_reg) << LOG2_PS) + 32'(c_reg);
  assign rd_addr = AW'(32'(r_reg) * 32'(MAX_IMAGE_SIZE) + dcol);
  assign wr_addr = AW'(32'(row_reg) * 32'(MAX_IMAGE_SIZE) + 32'(col_reg));

`ifdef VT512_PATCH_ZEROPAD_EN
  logic [31:0] drow;
  assign npx_new = (image_size + PS_M1) >> LOG2_PS;
  assign drow    = (32'(strip_reg) << LOG2_PS) + 32'(r_reg);
  assign rd_zero = (dcol >= 32'(w_reg)) || (drow >= 32'(w_reg));
  assign wr_en   = (state_reg == FILL) && pix_hs;
`else
  assign npx_new = image_size >> LOG2_PS;
  assign rd_zero = 1'b0;
  // Columns past the last whole patch are accepted but never stored.
  assign wr_en   = (state_reg == FILL) && pix_hs && (col_reg < (npx_reg << LOG2_PS));
`endif

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (size_detection_done && size_ok) state_next = FILL;
      FILL:    if (fill_end) state_next = DRAIN;
      DRAIN: begin
        if (drain_exit) begin
          if (more_strips)               state_next = FILL;
          else if (img_row_reg < w_reg)  state_next = DISCARD;
          else                           state_next = IDLE;
        end
      end
      DISCARD: if (discard_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Counters, token sideband and status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      w_reg          <= '0;
      npx_reg        <= '0;
      strip_reg      <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      img_row_reg    <= '0;
      p_reg          <= '0;
      r_reg          <= '0;
      c_reg          <= '0;
      strip_base_reg <= '0;
      patch_idx_reg  <= '0;
      tok_valid_reg  <= 1'b0;
      tok_last_reg   <= 1'b0;
      strip_end_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      size_err_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (size_detection_done) begin
            if (size_ok) begin
              w_reg          <= image_size;
              npx_reg        <= npx_new;
              strip_reg      <= '0;
              strip_base_reg <= '0;
              row_reg        <= '0;
              col_reg        <= '0;
              img_row_reg    <= '0;
            end else begin
              size_err_reg <= 1'b1;
            end
          end
        end
        FILL: begin
          if (pix_hs) begin
            if (col_last) begin
              col_reg     <= '0;
              row_reg     <= row_reg + ONE;
              img_row_reg <= img_row_reg + ONE;
            end else begin
              col_reg <= col_reg + ONE;
            end
            if (fill_end) begin
              p_reg <= '0;
              r_reg <= '0;
              c_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_load) begin
            tok_valid_reg <= 1'b1;
            tok_last_reg  <= (r_reg == PS_M1) && (c_reg == PS_M1);
            strip_end_reg <= (r_reg == PS_M1) && (c_reg == PS_M1) && (p_reg == npx_reg - ONE);
            patch_idx_reg <= strip_base_reg + 16'(p_reg);
            if (c_reg == PS_M1) begin
              c_reg <= '0;
              if (r_reg == PS_M1) begin
                r_reg <= '0;
                p_reg <= p_reg + ONE;
              end else begin
                r_reg <= r_reg + ONE;
              end
            end else begin
              c_reg <= c_reg + ONE;
            end
          end else if (drain_exit) begin
            tok_valid_reg <= 1'b0;
            tok_last_reg  <= 1'b0;
            strip_end_reg <= 1'b0;
            col_reg       <= '0;
            if (more_strips) begin
              strip_reg      <= strip_reg + ONE;
              strip_base_reg <= strip_base_reg + 16'(npx_reg);
              row_reg        <= '0;
            end else begin
              frame_done_reg <= 1'b1;
            end
          end
        end
        DISCARD: begin
          if (pix_hs) begin
            if (col_last) begin
              col_reg     <= '0;
              img_row_reg <= img_row_reg + ONE;
            end else begin
              col_reg <= col_reg + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strip buffer; the read register doubles as the token data register
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_addr] <= pix_data;
    if (wb_rst_i)        tok_data_reg <= '0;
    else if (drain_load) tok_data_reg <= rd_zero ? '0 : mem[rd_addr];
  end

  assign tok_valid  = tok_valid_reg;
  assign tok_data   = tok_data_reg;
  assign tok_last   = tok_last_reg;
  assign patch_idx  = patch_idx_reg;
  assign frame_done = frame_done_reg;
  assign size_err   = size_err_reg;

endmodule

// File: tb/tb_vt512_patch_tokenizer.sv
// Directed bench for vt512_patch_tokenizer (PATCH_SIZE=4, MAX_IMAGE_SIZE=16).
`timescale 1ns/1ps
module tb_vt512_patch_tokenizer;

  localparam int DW   = 32;
  localparam int MAXS = 16;
  localparam int PS   = 4;
  localparam int SW   = 5;
`ifdef VT512_PATCH_ZEROPAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] image_size = '0;
  logic          size_detection_done = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] pix_data = '0;
  logic          tok_valid;
  logic          tok_ready = 1'b0;
  logic [DW-1:0] tok_data;
  logic          tok_last;
  logic [15:0]   patch_idx;
  logic          frame_done;
  logic          size_err;

  vt512_patch_tokenizer #(.DATA_WIDTH(DW), .MAX_IMAGE_SIZE(MAXS), .PATCH_SIZE(PS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .image_size(image_size),
    .size_detection_done(size_detection_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
    .tok_last(tok_last), .patch_idx(patch_idx),
    .frame_done(frame_done), .size_err(size_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [15:0] got_idx[$];
  int fd_count, pix_count, stall_viol, stall_cycles, overlap;
  bit timed_out;

  // Expected token k of a frame of side w (patch order, rows then columns).
  function automatic logic [31:0] exp_data(input int w, input bit zp, input int k);
    int npx, g, s, p, row, col;
    npx = zp ? (w + PS - 1) / PS : w / PS;
    g   = k / (PS * PS);
    s   = g / npx;
    p   = g % npx;
    row = s * PS + (k % (PS * PS)) / PS;
    col = p * PS + k % PS;
    if (row >= w || col >= w) return 32'h0;
    return 32'(row * 16 + col);
  endfunction

  // Feeds one w*w frame and records every accepted token.
  task automatic run_frame(input int w, input bit stall);
    int k, tail;
    bit prev_stall, done;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [15:0] prev_idx;
    got_data.delete(); got_last.delete(); got_idx.delete();
    fd_count = 0; pix_count = 0; stall_viol = 0; stall_cycles = 0; overlap = 0;
    timed_out = 0; k = 0; tail = 0; prev_stall = 0; done = 0;
    prev_data = '0; prev_last = 1'b0; prev_idx = '0;
    @(negedge clk);
    image_size = SW'(w);
    size_detection_done = 1'b1;
    @(negedge clk);
    size_detection_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (frame_done) fd_count++;
      if (pix_ready && tok_valid) overlap++;
      if (prev_stall && (tok_valid !== 1'b1 || tok_data !== prev_data ||
                         tok_last !== prev_last || patch_idx !== prev_idx)) stall_viol++;
      if (k < w * w) begin
        pix_valid = 1'b1;
        pix_data  = 32'((k / w) * 16 + k % w);
      end else begin
        pix_valid = 1'b0;
        pix_data  = '0;
      end
      tok_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pix_ready && pix_valid) begin k++; pix_count++; end
      if (tok_valid && tok_ready) begin
        got_data.push_back(tok_data);
        got_last.push_back(tok_last);
        got_idx.push_back(patch_idx);
      end
      prev_stall = tok_valid && !tok_ready;
      if (prev_stall) stall_cycles++;
      prev_data = tok_data; prev_last = tok_last; prev_idx = patch_idx;
      if (tail > 0) begin
        tail++;
        if (tail > 6) done = 1;
      end else if (fd_count > 0 && k == w * w && !pix_ready && !tok_valid) begin
        tail = 1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) timed_out = 1;
    pix_valid = 1'b0;
    tok_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
    checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL reset_tok_valid: got %b want 0", tok_valid); end
    checks++; if (tok_last !== 1'b0) begin errors++; $display("FAIL reset_tok_last: got %b want 0", tok_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL reset_size_err: got %b want 0", size_err); end
    checks++; if (patch_idx !== 16'h0) begin errors++; $display("FAIL reset_patch_idx: got %0h want 0", patch_idx); end
    checks++; if (tok_data !== 32'h0) begin errors++; $display("FAIL reset_tok_data: got %0h want 0", tok_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL idle_pix_ready: got %b want 0", pix_ready); end
    $display("test_reset done");
  endtask

  task automatic test_size_err();
    int sizes[2];
    sizes[0] = 3; sizes[1] = 17;
    foreach (sizes[i]) begin
      @(negedge clk);
      image_size = SW'(sizes[i]);
      size_detection_done = 1'b1;
      @(negedge clk);
      size_detection_done = 1'b0;
      pix_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (size_err !== 1'b1) begin errors++; $display("FAIL size_err_set w=%0d: got %b want 1", sizes[i], size_err); end
      checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL size_err_pix_ready w=%0d: got %b want 0", sizes[i], pix_ready); end
      pix_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL size_err_clear w=%0d: got %b want 0", sizes[i], size_err); end
      $display("size check w=%0d size_err cleared by reset", sizes[i]);
    end
  endtask

  task automatic test_w8_basic();
    int bad, first, nlast;
    run_frame(8, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL w8_timeout: got timeout want frame end"); end
    checks++; if (got_data.size() != 64) begin errors++; $display("FAIL w8_count: got %0d want 64", got_data.size()); end
    bad = 0; first = -1; nlast = 0;
    for (int k = 0; k < got_data.size() && k < 64; k++) begin
      if (got_last[k]) nlast++;
      if (got_data[k] !== exp_data(8, ZP, k) || got_last[k] !== ((k % 16) == 15) ||
          got_idx[k] !== 16'(k / 16)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL w8_sequence: %0d bad words, first k=%0d got %0h/%b/%0d want %0h/%b/%0d", bad, first,
               got_data[first], got_last[first], got_idx[first], exp_data(8, ZP, first), (first % 16) == 15, first / 16);
    end
    checks++; if (nlast != 4) begin errors++; $display("FAIL w8_last_count: got %0d want 4", nlast); end
    if (got_data.size() >= 21) begin
      checks++; if (got_data[16] !== 32'h04) begin errors++; $display("FAIL w8_p1_w0: got %0h want 04", got_data[16]); end
      checks++; if (got_data[19] !== 32'h07) begin errors++; $display("FAIL w8_p1_w3: got %0h want 07", got_data[19]); end
      checks++; if (got_data[20] !== 32'h14) begin errors++; $display("FAIL w8_p1_w4: got %0h want 14", got_data[20]); end
    end
    checks++; if (fd_count != 1) begin errors++; $display("FAIL w8_frame_done: got %0d want 1", fd_count); end
    checks++; if (pix_count != 64) begin errors++; $display("FAIL w8_pixels: got %0d want 64", pix_count); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL w8_ready_overlap: got %0d want 0", overlap); end
    $display("test_w8_basic: %0d tokens, %0d frame_done", got_data.size(), fd_count);
  endtask

  task automatic test_w8_stall();
    int bad, first;
    run_frame(8, 1'b1);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout want frame end"); end
    checks++; if (got_data.size() != 64) begin errors++; $display("FAIL stall_count: got %0d want 64", got_data.size()); end
    bad = 0; first = -1;
    for (int k = 0; k < got_data.size() && k < 64; k++) begin
      if (got_data[k] !== exp_data(8, ZP, k) || got_last[k] !== ((k % 16) == 15) ||
          got_idx[k] !== 16'(k / 16)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_sequence: %0d bad words, first k=%0d got %0h want %0h", bad, first,
               got_data[first], exp_data(8, ZP, first));
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL stall_occurred: got 0 stall cycles want >0"); end
    checks++; if (fd_count != 1) begin errors++; $display("FAIL stall_frame_done: got %0d want 1", fd_count); end
    $display("test_w8_stall: %0d tokens, %0d stall cycles", got_data.size(), stall_cycles);
  endtask

  task automatic test_w6();
    int bad, first, ntok;
    run_frame(6, 1'b0);
    ntok = ZP ? 64 : 16;
    checks++; if (timed_out) begin errors++; $display("FAIL w6_timeout: got timeout want frame end"); end
    checks++; if (got_data.size() != ntok) begin errors++; $display("FAIL w6_count: got %0d want %0d", got_data.size(), ntok); end
    bad = 0; first = -1;
    for (int k = 0; k < got_data.size() && k < ntok; k++) begin
      if (got_data[k] !== exp_data(6, ZP, k) || got_last[k] !== ((k % 16) == 15) ||
          got_idx[k] !== 16'(k / 16)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL w6_sequence: %0d bad words, first k=%0d got %0h want %0h", bad, first,
               got_data[first], exp_data(6, ZP, first));
    end
    checks++; if (pix_count != 36) begin errors++; $display("FAIL w6_pixels: got %0d want 36", pix_count); end
    checks++; if (fd_count != 1) begin errors++; $display("FAIL w6_frame_done: got %0d want 1", fd_count); end
`ifdef VT512_PATCH_ZEROPAD_EN
    if (got_data.size() == 64) begin
      checks++;
      if (got_data[16] !== 32'h04 || got_data[17] !== 32'h05 || got_data[18] !== 32'h0 || got_data[19] !== 32'h0) begin
        errors++;
        $display("FAIL w6_p1_row0: got %0h %0h %0h %0h want 4 5 0 0", got_data[16], got_data[17], got_data[18], got_data[19]);
      end
      bad = 0;
      for (int k = 56; k < 64; k++) if (got_data[k] !== 32'h0) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL w6_p3_pad: got %0d nonzero words want 0", bad); end
    end
`else
    if (got_data.size() == 16) begin
      checks++; if (got_data[15] !== 32'h33) begin errors++; $display("FAIL w6_last_word: got %0h want 33", got_data[15]); end
    end
`endif
    // Only IDLE reacts to a size pulse, so size_err proves the block returned there.
    @(negedge clk);
    image_size = SW'(3);
    size_detection_done = 1'b1;
    @(negedge clk);
    size_detection_done = 1'b0;
    @(negedge clk);
    checks++; if (size_err !== 1'b1) begin errors++; $display("FAIL w6_back_to_idle: size_err got %b want 1", size_err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("test_w6 zp=%0d: %0d tokens, %0d pixels", ZP, got_data.size(), pix_count);
  endtask

  task automatic test_reset_mid_drain();
    int k, fd, tv;
    bit seen;
    k = 0; seen = 0; fd = 0; tv = 0;
    @(negedge clk);
    image_size = SW'(8);
    size_detection_done = 1'b1;
    @(negedge clk);
    size_detection_done = 1'b0;
    tok_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (tok_valid) begin
        seen = 1;
      end else begin
        pix_valid = (k < 64);
        pix_data  = 32'((k / 8) * 16 + k % 8);
        if (pix_ready && pix_valid) k++;
        @(negedge clk);
      end
    end
    pix_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL mid_drain_reach: got no tok_valid want drain"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL mid_drain_tok_valid: got %b want 0", tok_valid); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL mid_drain_pix_ready: got %b want 0", pix_ready); end
    checks++; if (patch_idx !== 16'h0 || tok_data !== 32'h0) begin errors++; $display("FAIL mid_drain_outputs: got idx %0h data %0h want 0 0", patch_idx, tok_data); end
    rst = 1'b0;
    tok_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (frame_done) fd++;
      if (tok_valid) tv++;
      @(negedge clk);
    end
    tok_ready = 1'b0;
    checks++; if (fd != 0) begin errors++; $display("FAIL mid_drain_frame_done: got %0d want 0", fd); end
    checks++; if (tv != 0) begin errors++; $display("FAIL mid_drain_idle: got %0d valid cycles want 0", tv); end
    run_frame(8, 1'b0);
    checks++; if (got_data.size() != 64 || timed_out) begin errors++; $display("FAIL after_reset_frame: got %0d tokens want 64", got_data.size()); end
    $display("test_reset_mid_drain: frame after reset gave %0d tokens", got_data.size());
  endtask

  initial begin
    test_reset();
    test_size_err();
    test_w8_basic();
    test_w8_stall();
    test_w6();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
